// File: rtl/mmio_audio_pwm.sv
// Memory-mapped multi-channel PWM audio peripheral: direct duty registers or a shared
// sample FIFO drained at a fixed sample rate, with sticky underrun/overflow interrupt.
module mmio_audio_pwm #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned PWM_BITS   = 10,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SAMPLE_DIV = 1136,
  parameter logic [31:0] BASE_ADDR  = 32'd4098
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wEn,
  input  logic [31:0]       addr,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              hit,
  output logic [NUM_CH-1:0] audioOut,
  output logic              irq
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DivW = $clog2(SAMPLE_DIV);
  localparam logic [31:0] OffFifo = 32'(2 + NUM_CH);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [DivW-1:0] DivMax = DivW'(SAMPLE_DIV - 1);

  logic                r_enable;
  logic [NUM_CH-1:0]   r_src;
  logic [PWM_BITS-1:0] r_duty [NUM_CH];
  logic [PWM_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wptr, r_rptr;
  logic [CntW-1:0]     r_count;
  logic [PWM_BITS-1:0] r_last;
  logic                r_underrun, r_overflow, r_irq;
  logic [PWM_BITS-1:0] r_cnt;
  logic [DivW-1:0]     r_div;
  logic [PWM_BITS-1:0] r_active [NUM_CH];
  logic [NUM_CH-1:0]   r_audio;

  logic [31:0] w_off, w_rdata;
  logic        w_hit, w_wr, w_wr_ctrl, w_clr, w_tick;
  logic        w_empty, w_full, w_pop_req, w_push_req, w_pop, w_push;
  logic        w_underrun_set, w_overflow_set;

  assign w_off      = addr - BASE_ADDR;
  assign w_hit      = (addr >= BASE_ADDR) && (w_off <= OffFifo);
  assign w_wr       = wEn && w_hit;
  assign w_wr_ctrl  = w_wr && (w_off == 32'd0);
  assign w_clr      = w_wr && (w_off == 32'd1);
  assign w_tick     = (r_div == DivMax);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntFull);
  assign w_pop_req  = w_tick && r_enable;
  assign w_push_req = w_wr && (w_off == OffFifo);
  assign w_pop      = w_pop_req && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign w_push         = w_push_req && (!w_full || w_pop);
  assign w_underrun_set = w_pop_req && w_empty;
  assign w_overflow_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_enable <= 1'b0;
      r_src    <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= dataIn[0];
        r_src    <= dataIn[8 +: NUM_CH];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr && (w_off == 32'(2 + i))) r_duty[i] <= dataIn[PWM_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= dataIn[PWM_BITS-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
        r_last <= r_mem[r_rptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Set events are OR-ed in after the clear so they win in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_underrun <= (r_underrun && !(w_clr && dataIn[0])) || w_underrun_set;
      r_overflow <= (r_overflow && !(w_clr && dataIn[1])) || w_overflow_set;
      r_irq      <= r_underrun || r_overflow;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_div   <= '0;
      r_audio <= '0;
      for (int i = 0; i < NUM_CH; i++) r_active[i] <= '0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      r_div <= w_tick ? '0 : r_div + DivW'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        r_audio[i] <= r_enable && (r_cnt < r_active[i]);
        // Latch the next period's duty only at wrap so mid-period updates never glitch.
        if (r_cnt == '1) r_active[i] <= r_src[i] ? r_last : r_duty[i];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      if (w_off == 32'd0) begin
        w_rdata[0]           = r_enable;
        w_rdata[8 +: NUM_CH] = r_src;
      end else if (w_off == 32'd1) begin
        w_rdata = {8'd0, 8'(r_count), 12'd0, w_full, w_empty, r_overflow, r_underrun};
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_off == 32'(2 + i)) w_rdata = 32'(r_duty[i]);
        end
      end
    end
  end

  assign dataOut  = w_rdata;
  assign hit      = w_hit;
  assign audioOut = r_audio;
  assign irq      = r_irq;

endmodule

// File: doc/mmio_audio_pwm.md
Name: mmio_audio_pwm

Overview:
Memory-mapped, multi-channel PWM audio peripheral on the processor data bus, alongside the RAM and the switch/LED I/O decode. It generalises the single 10-bit duty-cycle register to NUM_CH channels of PWM_BITS resolution. Each channel can be driven by a direct duty register, or by a shared sample FIFO drained at a fixed sample rate. Overflow and underrun are reported through a readable status register and a sticky interrupt line.

Parameters:
NUM_CH, 2, number of PWM output channels (1..8)
PWM_BITS, 10, duty/sample resolution; PWM period is 2^PWM_BITS clocks
FIFO_DEPTH, 16, sample FIFO entries; power of two, >=2
SAMPLE_DIV, 1136, clocks per sample tick (50 MHz / 44 kHz); >=2
BASE_ADDR, 32'd4098, word address of register 0

Ports:
clock  in  1  system clock (50 MHz domain)
reset  in  1  asynchronous, active-low reset
wEn  in  1  store strobe from processor (wren)
addr  in  32  processor data address (address_dmem)
dataIn  in  32  store data
dataOut  out  32  read data; combinational; valid when hit=1
hit  out  1  addr falls inside this block's register window
audioOut  out  NUM_CH  PWM outputs, one per channel
irq  out  1  OR of sticky underrun and overflow flags

Behaviour:
- Register map, as word offsets from BASE_ADDR:
  - +0 CTRL, R/W: bit0 = global enable; bits[8+NUM_CH-1:8] = per-channel source select (1 = FIFO, 0 = direct).
  - +1 STATUS, R; a write of 1s clears: bit0 = underrun (write-1-clear); bit1 = overflow (write-1-clear); bit2 = empty; bit3 = full; bits[23:16] = fill level.
  - +2..+1+NUM_CH DUTY[ch], R/W: bits[PWM_BITS-1:0].
  - +2+NUM_CH FIFO push, W only; reads return 0.
- hit is asserted for addr in [BASE_ADDR, BASE_ADDR+2+NUM_CH]. Addresses outside that window are ignored and dataOut is 0. Reads have no side effects. Unused read bits are 0.
- Writes take effect on the posedge clock where wEn=1 and hit=1. Only the low PWM_BITS of dataIn are stored for DUTY and FIFO.
- Reset (reset=0, async):
  - CTRL=0, all DUTY=0, FIFO empty, last_sample=0, flags=0.
  - PWM counter=0, sample divider=0, audioOut=0, irq=0.
- PWM:
  - A single free-running counter cnt counts 0..2^PWM_BITS-1 and wraps.
  - active[ch] is latched only when cnt wraps to 0, which makes duty updates glitch-free mid-period. active[ch] = last_sample if the source bit is 1, else DUTY[ch].
  - audioOut[ch] is registered and equals (enable && cnt < active[ch]).
  - Duty 0 gives constant low. Full-scale 2^PWM_BITS-1 gives high for all but one clock per period.
  - With enable=0, outputs are 0, but the counter and sample divider keep running.
- Sample tick:
  - The divider counts 0..SAMPLE_DIV-1; tick pulses for one cycle at the wrap.
  - On tick with enable=1: if the FIFO is not empty, pop into last_sample. If it is empty, hold last_sample and set underrun.
  - On tick with enable=0: nothing is popped and no flag is set.
- FIFO:
  - Circular buffer with read/write pointers and a count; fill level ranges 0..FIFO_DEPTH.
  - Push when full: data dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle: both performed and count unchanged. This includes the full case, where the push is accepted because the pop frees a slot. The empty case cannot arise, since the pop is not performed and underrun is set instead.
- Flags:
  - Flags are sticky until cleared by a STATUS write with 1 in the corresponding bit.
  - A set event in the same cycle as a clear wins: the flag stays 1.
- irq is registered and follows the flags one cycle later.
- Writing CTRL does not flush the FIFO.

Test Plan:
- Reset: hold reset=0, poke wEn/addr -> audioOut=0, irq=0, STATUS reads 0x4 (empty=1). Release -> cnt starts at 0.
- Direct mode: CTRL=1, DUTY[0]=256, DUTY[1]=0 -> audioOut[0] high 256 of every 1024 clocks; audioOut[1] constant 0. Change DUTY[0] mid-period -> new width appears only from the next period.
- FIFO fill: disabled, push 17 samples with FIFO_DEPTH=16 -> STATUS level=16, full=1, overflow=1, irq=1 next cycle. Write STATUS=0x2 -> overflow=0, irq=0.
- FIFO playback: CTRL=0x301, push 100, 200, 300 -> last_sample takes 100, 200, 300 on successive ticks 1136 clocks apart. The 4th tick sets underrun, and output holds duty 300.
- Simultaneous events: full FIFO with push on a tick cycle -> level stays 16, no overflow. Empty FIFO with a clear-underrun write on a tick -> underrun remains 1.
- Mid-operation reset: assert reset during playback -> all outputs 0 immediately (async), FIFO level 0 after release.
